// File: rtl/t03_fetch_cache_ctrl.sv
// Direct-mapped one-word-per-line instruction cache with a shared memory request unit.
// Data accesses win over fetch misses; stores update cached words write-through.
module t03_fetch_cache_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINES  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_fetch_req,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  input  logic              i_data_read,
  input  logic              i_data_write,
  input  logic [ADDR_W-1:0] i_data_addr,
  input  logic [DATA_W-1:0] i_data_wdata,
  input  logic              i_flush,
  input  logic              i_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [DATA_W-1:0] o_instr_out,
  output logic              o_instr_valid,
  output logic              o_data_done,
  output logic              o_freeze_pc,
  output logic [CNT_W-1:0]  o_hit_count,
  output logic [CNT_W-1:0]  o_miss_count
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  // state | meaning
  // IDLE       | serve flush, data request, fetch hit or start fetch miss
  // FETCH_WAIT | memory read for a line fill
  // DATA_WAIT  | memory load/store on behalf of the data port
  // DONE       | one bubble so requesters can drop their levels
  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_FETCH_WAIT = 2'd1;
  localparam logic [1:0] S_DATA_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE       = 2'd3;

  logic [1:0]        r_state;
  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [DATA_W-1:0] r_data [LINES];
  logic              r_flush_pend;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_instr_out;
  logic              r_instr_valid;
  logic [CNT_W-1:0]  r_hit_count;
  logic [CNT_W-1:0]  r_miss_count;

  logic [IDX_W-1:0]  w_f_idx;
  logic [TAG_W-1:0]  w_f_tag;
  logic              w_f_hit;
  logic [IDX_W-1:0]  w_m_idx;
  logic [TAG_W-1:0]  w_m_tag;
  logic              w_m_hit;
  logic              w_data_req;
  logic              w_flush_now;

  assign w_f_idx     = i_fetch_addr[IDX_W+1:2];
  assign w_f_tag     = i_fetch_addr[ADDR_W-1:IDX_W+2];
  assign w_f_hit     = r_valid[w_f_idx] & (r_tag[w_f_idx] == w_f_tag);
  assign w_m_idx     = r_mem_addr[IDX_W+1:2];
  assign w_m_tag     = r_mem_addr[ADDR_W-1:IDX_W+2];
  assign w_m_hit     = r_valid[w_m_idx] & (r_tag[w_m_idx] == w_m_tag);
  assign w_data_req  = i_data_read | i_data_write;
  assign w_flush_now = i_flush | r_flush_pend;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_valid       <= '0;
      r_flush_pend  <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_addr    <= '0;
      r_instr_out   <= '0;
      r_instr_valid <= 1'b0;
      r_hit_count   <= '0;
      r_miss_count  <= '0;
    end else begin
      r_instr_valid <= 1'b0;
      if (i_flush && (r_state != S_IDLE)) r_flush_pend <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_flush_now) begin
            r_valid      <= '0;
            r_flush_pend <= 1'b0;
          end else if (w_data_req) begin
            r_state     <= S_DATA_WAIT;
            r_mem_addr  <= i_data_addr;
            // both strobes high is illegal and is treated as a store
            r_mem_write <= i_data_write;
            r_mem_read  <= ~i_data_write;
          end else if (i_fetch_req) begin
            if (w_f_hit) begin
              r_instr_out   <= r_data[w_f_idx];
              r_instr_valid <= 1'b1;
              if (r_hit_count != '1) r_hit_count <= r_hit_count + 1'b1;
            end else begin
              r_state     <= S_FETCH_WAIT;
              r_mem_addr  <= i_fetch_addr;
              r_mem_read  <= 1'b1;
              r_mem_write <= 1'b0;
              if (r_miss_count != '1) r_miss_count <= r_miss_count + 1'b1;
            end
          end
        end
        S_FETCH_WAIT: begin
          if (i_ack) begin
            r_valid[w_m_idx] <= 1'b1;
            r_instr_out      <= i_mem_rdata;
            r_instr_valid    <= 1'b1;
            r_mem_read       <= 1'b0;
            r_state          <= S_DONE;
          end
        end
        S_DATA_WAIT: begin
          if (i_ack) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_state     <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Line storage carries no reset; the valid bits guard it.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if ((r_state == S_FETCH_WAIT) && i_ack) begin
        r_tag[w_m_idx]  <= w_m_tag;
        r_data[w_m_idx] <= i_mem_rdata;
      end else if ((r_state == S_DATA_WAIT) && i_ack && r_mem_write && w_m_hit) begin
        r_data[w_m_idx] <= i_data_wdata;
      end
    end
  end

  assign o_mem_read    = r_mem_read;
  assign o_mem_write   = r_mem_write;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_wdata   = i_data_wdata;
  assign o_instr_out   = r_instr_out;
  assign o_instr_valid = r_instr_valid;
  assign o_data_done   = (r_state == S_DATA_WAIT) & i_ack;
  assign o_freeze_pc   = (r_state != S_IDLE) | w_data_req | (i_fetch_req & ~w_f_hit) | w_flush_now;
  assign o_hit_count   = r_hit_count;
  assign o_miss_count  = r_miss_count;

endmodule
